// File: rtl/gb_int_pkg.sv
// Shared types, default addresses and vector helper for the interrupt unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Decoded CPU bus strobes for the two registers of this block.
  typedef struct packed {
    logic wr_if;
    logic wr_ie;
    logic rd_if;
    logic rd_ie;
  } bus_dec_t;

  localparam logic [15:0] DEF_IF_ADDR    = 16'hFF0F;
  localparam logic [15:0] DEF_IE_ADDR    = 16'hFFFF;
  localparam logic [7:0]  DEF_VEC_BASE   = 8'hA0;
  localparam logic [7:0]  DEF_VEC_STRIDE = 8'h02;
  localparam int          IDX_W          = 3;

  // Vector of source idx; the 8-bit result wraps modulo 256.
  function automatic logic [7:0] vec_addr(input logic [7:0]       base,
                                          input logic [7:0]       stride,
                                          input logic [IDX_W-1:0] idx);
    logic [15:0] prod;
    prod = {8'h00, stride} * {13'h0000, idx};
    return base + prod[7:0];
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of pend wins.
// Latency: combinational.
// Backpressure: none.
// Ports: pend (pending vector) -> sel (winning index), any (pend != 0).
module irq_prio_enc
  import gb_int_pkg::*;
#(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Edge-latching interrupt controller with IF/IE registers and a Z80-style INTA handshake.
// Latency: request edge -> int_n low in 3 clocks; register read data 1 clock after the strobe.
// Backpressure: none; requests stay pending in IF until the CPU acknowledges or software clears them.
// Ports: clock/reset_n; int_req/int_ack per source; m1_n/iorq_n/int_n/jump_addr to the CPU;
//        A/Di/Do/wr_n/rd_n/cs CPU register port (Do reads 8'hFF when cs is low).
module interrupt_ctrl
  import gb_int_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [7:0]  VEC_BASE   = DEF_VEC_BASE,
  parameter logic [7:0]  VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [15:0] IF_ADDR    = DEF_IF_ADDR,
  parameter logic [15:0] IE_ADDR    = DEF_IE_ADDR
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] int_req,
  output logic [NUM_IRQ-1:0] int_ack,
  input  logic               m1_n,
  input  logic               iorq_n,
  output logic               int_n,
  output logic [7:0]         jump_addr,
  input  logic [15:0]        A,
  input  logic [7:0]         Di,
  output logic [7:0]         Do,
  input  logic               wr_n,
  input  logic               rd_n,
  input  logic               cs
);

  state_e             state, state_d;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] ie_q;
  logic [7:0]         reg_out;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [7:0]         jump_d;
  logic               int_n_d;
  logic [NUM_IRQ-1:0] int_ack_d;

  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [IDX_W-1:0]   sel;
  logic               pend_any;
  logic               inta;
  bus_dec_t           bus;
  logic [7:0]         rd_if, rd_ie;
  logic               unused_di;

  // Upper Di bits only matter when NUM_IRQ is 8.
  assign unused_di = &{1'b0, Di};

  assign set_vec = int_req & ~req_q;
  assign pend    = if_q & ie_q;
  assign inta    = ~m1_n & ~iorq_n;

  always_comb begin
    bus       = '0;
    bus.wr_if = cs & ~wr_n & (A == IF_ADDR);
    bus.wr_ie = cs & ~wr_n & (A == IE_ADDR);
    bus.rd_if = cs & ~rd_n & wr_n & (A == IF_ADDR);
    bus.rd_ie = cs & ~rd_n & wr_n & (A == IE_ADDR);
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .pend (pend),
    .sel  (sel),
    .any  (pend_any)
  );

  // One-hot of the selected source, and of the source being cleared while in ACK.
  always_comb begin
    sel_oh  = '0;
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_oh[i] = 1'b1;
      end
      if ((state == ACK) && (idx == IDX_W'(i))) begin
        ack_clr[i] = 1'b1;
      end
    end
  end

  // A fresh edge beats both the ack clear and a CPU write, so no request is lost.
  always_comb begin
    if_d = set_vec | (~ack_clr & (bus.wr_if ? Di[NUM_IRQ-1:0] : if_q));
  end

  // Unimplemented upper bits read as 1.
  always_comb begin
    rd_if                = 8'hFF;
    rd_if[NUM_IRQ-1:0]   = if_q;
    rd_ie                = 8'hFF;
    rd_ie[NUM_IRQ-1:0]   = ie_q;
  end

  assign Do = cs ? reg_out : 8'hFF;

  // Outputs are registered from the next-state decision: int_n drops one clock
  // after REQ is entered, and int_ack is high exactly while in ACK.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    jump_d    = jump_addr;
    int_n_d   = 1'b1;
    int_ack_d = '0;
    case (state)
      IDLE: begin
        if (pend_any) begin
          state_d = REQ;
          idx_d   = sel;
          jump_d  = vec_addr(VEC_BASE, VEC_STRIDE, sel);
        end
      end
      REQ: begin
        if (!pend_any) begin
          // Software withdrew the request before INTA.
          state_d = IDLE;
        end else begin
          // Keep tracking the winner so a higher-priority arrival pre-empts;
          // the INTA cycle takes the final value, after which idx/jump_addr hold.
          idx_d  = sel;
          jump_d = vec_addr(VEC_BASE, VEC_STRIDE, sel);
          if (inta) begin
            state_d   = ACK;
            int_ack_d = sel_oh;
          end else begin
            int_n_d = 1'b0;
          end
        end
      end
      ACK: begin
        state_d = DONE;
      end
      DONE: begin
        if (m1_n | iorq_n) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_q     <= '0;
      if_q      <= '0;
      ie_q      <= '0;
      reg_out   <= 8'hFF;
      idx       <= '0;
      jump_addr <= VEC_BASE;
      int_n     <= 1'b1;
      int_ack   <= '0;
    end else begin
      state     <= state_d;
      req_q     <= int_req;
      if_q      <= if_d;
      idx       <= idx_d;
      jump_addr <= jump_d;
      int_n     <= int_n_d;
      int_ack   <= int_ack_d;
      if (bus.wr_ie) begin
        ie_q <= Di[NUM_IRQ-1:0];
      end
      if (bus.rd_if) begin
        reg_out <= rd_if;
      end else if (bus.rd_ie) begin
        reg_out <= rd_ie;
      end
    end
  end

endmodule
